// File: rtl/gate_buffer_core.sv
// gate_buffer_core: track/hold sample gate with registered gate-edge pulses
// and a saturating count of consecutive hold cycles. Every output comes
// straight from a flip-flop.
module gate_buffer_core #(
  parameter int DATA_SIZE  = 14,
  parameter int COUNT_SIZE = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_SIZE-1:0]  i_data,
  input  logic                  i_gate,
  output logic [DATA_SIZE-1:0]  o_data,
  output logic                  o_valid,
  output logic                  o_gate_rise,
  output logic                  o_gate_fall,
  output logic [COUNT_SIZE-1:0] o_hold_count
);

  localparam logic [COUNT_SIZE-1:0] CNT_MAX = {COUNT_SIZE{1'b1}};
  localparam logic [COUNT_SIZE-1:0] CNT_ONE = {{(COUNT_SIZE-1){1'b0}}, 1'b1};

  logic [DATA_SIZE-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  gate_q, gate_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic [COUNT_SIZE-1:0] cnt_q, cnt_d;

  // Next-state: capture while gate is high, hold otherwise; edges are
  // judged between the incoming gate and its registered copy.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    gate_d  = i_gate;
    rise_d  = i_gate & ~gate_q;
    fall_d  = ~i_gate & gate_q;
    if (i_gate) begin
      data_d  = i_data;
      valid_d = 1'b1;
      cnt_d   = {COUNT_SIZE{1'b0}};
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      data_q  <= {DATA_SIZE{1'b0}};
      valid_q <= 1'b0;
      gate_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= {COUNT_SIZE{1'b0}};
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      gate_q  <= gate_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_gate_rise  = rise_q;
  assign o_gate_fall  = fall_q;
  assign o_hold_count = cnt_q;

endmodule

// File: tb/tb_gate_buffer_core.sv
// Self-checking bench for gate_buffer_core: directed vector table, randomized
// run against a behavioural model, saturation and gate-toggle sequences.
module tb_gate_buffer_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        gate;
  logic [13:0] data;
  logic [13:0] o_data;
  logic        o_valid, o_rise, o_fall;
  logic [15:0] o_cnt;

  logic        rst2;
  logic        gate2;
  logic [7:0]  data2;
  logic [7:0]  o_data2;
  logic        o_valid2, o_rise2, o_fall2;
  logic [1:0]  o_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state (default instance)
  int m_data, m_valid, m_prev, m_rise, m_fall, m_cnt;
  localparam int M_MAX = 65535;

  always #5 clk = ~clk;

  gate_buffer_core #(.DATA_SIZE(14), .COUNT_SIZE(16)) dut (
    .i_clock(clk), .i_reset(rst), .i_data(data), .i_gate(gate),
    .o_data(o_data), .o_valid(o_valid), .o_gate_rise(o_rise),
    .o_gate_fall(o_fall), .o_hold_count(o_cnt)
  );

  gate_buffer_core #(.DATA_SIZE(8), .COUNT_SIZE(2)) dut2 (
    .i_clock(clk), .i_reset(rst2), .i_data(data2), .i_gate(gate2),
    .o_data(o_data2), .o_valid(o_valid2), .o_gate_rise(o_rise2),
    .o_gate_fall(o_fall2), .o_hold_count(o_cnt2)
  );

  typedef struct {
    logic        rst;
    logic        gate;
    logic [13:0] data;
    logic [13:0] e_data;
    logic        e_valid;
    logic        e_rise;
    logic        e_fall;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(logic r, logic g, int d, int ed, logic ev,
                              logic er, logic ef, int ec);
    vec_t v;
    v.rst = r; v.gate = g; v.data = d[13:0]; v.e_data = ed[13:0];
    v.e_valid = ev; v.e_rise = er; v.e_fall = ef; v.e_cnt = ec[15:0];
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // advance the model by one clock edge with the given inputs
  task automatic model_step(input logic r, input logic g, input int d);
    if (!r) begin
      m_data = 0; m_valid = 0; m_prev = 0; m_rise = 0; m_fall = 0; m_cnt = 0;
    end else begin
      m_rise = (g == 1'b1 && m_prev == 0) ? 1 : 0;
      m_fall = (g == 1'b0 && m_prev == 1) ? 1 : 0;
      m_prev = g ? 1 : 0;
      if (g) begin
        m_data = d; m_valid = 1; m_cnt = 0;
      end else begin
        m_cnt = (m_cnt < M_MAX) ? m_cnt + 1 : M_MAX;
      end
    end
  endtask

  // drive inputs, take one edge, sample #1 later
  task automatic step(input logic r, input logic g, input logic [13:0] d);
    rst = r; gate = g; data = d;
    @(posedge clk);
    model_step(r, g, int'(d));
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data"},  int'(o_data),  m_data);
    chk({tag, ".valid"}, int'(o_valid), m_valid);
    chk({tag, ".rise"},  int'(o_rise),  m_rise);
    chk({tag, ".fall"},  int'(o_fall),  m_fall);
    chk({tag, ".cnt"},   int'(o_cnt),   m_cnt);
  endtask

  initial begin
    int exp2[6];
    rst = 1'b0; gate = 1'b0; data = 14'd0;
    rst2 = 1'b0; gate2 = 1'b0; data2 = 8'd0;
    m_data = 0; m_valid = 0; m_prev = 0; m_rise = 0; m_fall = 0; m_cnt = 0;

    vt[0]  = mk(1'b0, 1'b0, 0,    0,    1'b0, 1'b0, 1'b0, 0);
    vt[1]  = mk(1'b0, 1'b1, 100,  0,    1'b0, 1'b0, 1'b0, 0);
    vt[2]  = mk(1'b1, 1'b1, 4000, 4000, 1'b1, 1'b1, 1'b0, 0);
    vt[3]  = mk(1'b1, 1'b0, 1111, 4000, 1'b1, 1'b0, 1'b1, 1);
    vt[4]  = mk(1'b1, 1'b0, 8192, 4000, 1'b1, 1'b0, 1'b0, 2);
    vt[5]  = mk(1'b1, 1'b0, 8192, 4000, 1'b1, 1'b0, 1'b0, 3);
    vt[6]  = mk(1'b1, 1'b1, 8192, 8192, 1'b1, 1'b1, 1'b0, 0);
    vt[7]  = mk(1'b1, 1'b1, 9999, 9999, 1'b1, 1'b0, 1'b0, 0);
    vt[8]  = mk(1'b1, 1'b1, 4000, 4000, 1'b1, 1'b0, 1'b0, 0);
    vt[9]  = mk(1'b1, 1'b0, 7,    4000, 1'b1, 1'b0, 1'b1, 1);
    vt[10] = mk(1'b0, 1'b0, 7,    0,    1'b0, 1'b0, 1'b0, 0);
    vt[11] = mk(1'b1, 1'b0, 55,   0,    1'b0, 1'b0, 1'b0, 1);
    vt[12] = mk(1'b1, 1'b0, 66,   0,    1'b0, 1'b0, 1'b0, 2);
    vt[13] = mk(1'b0, 1'b1, 123,  0,    1'b0, 1'b0, 1'b0, 0);
    vt[14] = mk(1'b1, 1'b1, 77,   77,   1'b1, 1'b1, 1'b0, 0);
    vt[15] = mk(1'b1, 1'b1, 78,   78,   1'b1, 1'b0, 1'b0, 0);

    // directed vector table
    for (int i = 0; i < 16; i++) begin
      step(vt[i].rst, vt[i].gate, vt[i].data);
      chk($sformatf("vec%0d.data", i),  int'(o_data),  int'(vt[i].e_data));
      chk($sformatf("vec%0d.valid", i), int'(o_valid), int'(vt[i].e_valid));
      chk($sformatf("vec%0d.rise", i),  int'(o_rise),  int'(vt[i].e_rise));
      chk($sformatf("vec%0d.fall", i),  int'(o_fall),  int'(vt[i].e_fall));
      chk($sformatf("vec%0d.cnt", i),   int'(o_cnt),   int'(vt[i].e_cnt));
    end

    // gate toggling every cycle with incrementing data
    step(1'b0, 1'b0, 14'd0);
    step(1'b0, 1'b0, 14'd0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 14'(i + 200));
      chk_model($sformatf("tog%0d", i));
      chk($sformatf("tog%0d.rise_or_fall", i), int'(o_rise ^ o_fall), 1);
    end

    // randomized run with occasional reset and long holds
    for (int i = 0; i < 400; i++) begin
      logic r, g;
      r = ($urandom_range(0, 29) != 0);
      g = (i % 100 < 60) ? 1'($urandom) : ($urandom_range(0, 9) == 0);
      step(r, g, 14'($urandom));
      chk_model($sformatf("rnd%0d", i));
    end

    // saturation on a 2-bit hold counter
    rst2 = 1'b0; gate2 = 1'b1; data2 = 8'd9;
    @(posedge clk); @(posedge clk); #1;
    chk("sat.reset_cnt", int'(o_cnt2), 0);
    rst2 = 1'b1; gate2 = 1'b1; data2 = 8'd42;
    @(posedge clk); #1;
    chk("sat.capture", int'(o_data2), 42);
    chk("sat.rise", int'(o_rise2), 1);
    exp2 = '{1, 2, 3, 3, 3, 3};
    for (int i = 0; i < 6; i++) begin
      gate2 = 1'b0; data2 = 8'(i + 1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d.cnt", i), int'(o_cnt2), exp2[i]);
      chk($sformatf("sat%0d.data", i), int'(o_data2), 42);
      chk($sformatf("sat%0d.fall", i), int'(o_fall2), (i == 0) ? 1 : 0);
    end
    gate2 = 1'b1; data2 = 8'd5;
    @(posedge clk); #1;
    chk("sat.clear", int'(o_cnt2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_buffer_core.md
GATE_BUFFER_CORE -- requirements
Module: gate_buffer

Interface
REQ-001 Parameter DATA_SIZE, default 14, width of the data path in bits (legal range 1..32).
REQ-002 Parameter COUNT_SIZE, default 16, width of the hold-duration counter in bits (legal range 2..32).
REQ-003 Port i_clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port i_reset  input  1  reset, synchronous and active-low; sampled on rising i_clock.
REQ-005 Port i_data  input  DATA_SIZE  sample to be gated through.
REQ-006 Port i_gate  input  1  gate control; 1 = track (pass), 0 = hold.
REQ-007 Port o_data  output  DATA_SIZE  gated/held data, registered.
REQ-008 Port o_valid  output  1  high once at least one sample has been captured since reset.
REQ-009 Port o_gate_rise  output  1  one-cycle pulse on a 0->1 transition of registered gate.
REQ-010 Port o_gate_fall  output  1  one-cycle pulse on a 1->0 transition of registered gate.
REQ-011 Port o_hold_count  output  COUNT_SIZE  consecutive cycles spent in hold, saturating.

Function
REQ-012 Track: at a rising edge with i_reset=1 and i_gate=1, o_data SHALL load i_data; latency exactly one clock.
REQ-013 Hold: at a rising edge with i_reset=1 and i_gate=0, o_data SHALL keep its previous value regardless of i_data.
REQ-014 i_data SHALL be passed bit-exact; no sign extension, scaling or truncation inside the block.
REQ-015 o_valid SHALL set on the first edge at which a track capture occurs and stay high until reset.
REQ-016 The block SHALL hold a registered copy gate_q of i_gate, updated every non-reset edge.
REQ-017 o_gate_rise SHALL be 1 for exactly the cycle after an edge where gate_q goes 0->1; otherwise 0.
REQ-018 o_gate_fall SHALL be 1 for exactly the cycle after an edge where gate_q goes 1->0; otherwise 0.
REQ-019 o_hold_count SHALL clear to 0 on any edge with i_gate=1 and increment by 1 on each edge with i_gate=0.
REQ-020 o_hold_count SHALL saturate at 2^COUNT_SIZE-1 and never wrap.
REQ-021 The first transition after reset SHALL be judged against gate_q reset value 0: gate high in the first cycle produces o_gate_rise, gate low produces no pulse.
REQ-022 All outputs SHALL be driven directly from flip-flops; no combinational path from inputs to outputs.
REQ-023 i_gate toggling every cycle SHALL be handled: alternating rise/fall pulses, o_hold_count alternating 0/1.

Reset
REQ-024 While i_reset=0 at a rising edge: o_data=0, o_valid=0, gate_q=0, o_gate_rise=0, o_gate_fall=0, o_hold_count=0.
REQ-025 Reset SHALL take priority over i_gate and i_data on the same edge, including mid-track and mid-hold.
REQ-026 On the first edge after reset release the block SHALL behave per REQ-012..REQ-021 with no extra warm-up cycle.
REQ-027 Before the first reset edge outputs are undefined; the bench SHALL apply reset for at least 2 cycles.

Verification
REQ-028 Reset 2 cycles, then i_gate=1, i_data=4000 -> next cycle o_data=4000, o_valid=1, o_gate_rise=1 for one cycle.
REQ-029 From tracking, i_gate=0, i_data=1111 then 0x2000 over 3 cycles -> o_data stays 4000, o_gate_fall=1 once, o_hold_count=1,2,3.
REQ-030 i_gate back to 1 with i_data=0x2000, then 9999 -> o_data=0x2000 then 9999, o_hold_count=0, o_gate_rise=1 once.
REQ-031 Reset asserted mid-hold with o_data=4000 -> next edge all outputs 0; after release with i_gate=0, o_valid stays 0 and o_data stays 0.
REQ-032 COUNT_SIZE=2, i_gate=0 for 6 cycles -> o_hold_count 1,2,3,3,3,3.
REQ-033 i_gate toggling every cycle with i_data incrementing -> o_data updates only from the cycles with gate high, and rise/fall pulses alternate each cycle.
